dm_responder: RTL and testbench

DM_RESPONDER -- requirements
Module: dm_responder

---
 rtl/dm_pkg.sv | 24 ++
 rtl/dm_array.sv | 50 +++++
 rtl/dm_responder.sv | 169 ++++++++++++++++
 tb/tb_dm_responder.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// ============================================================================
// Module : dm_pkg
// Brief  : Shared types and defaults for the data-memory responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    localparam int unsigned C_DEPTH_DEFAULT   = 3072;
    localparam logic [31:0] C_BASE_DEFAULT    = 32'h0000_0000;
    localparam int unsigned C_LATENCY_DEFAULT = 2;
    localparam int unsigned C_LATENCY_MAX     = 7;
    localparam int unsigned C_CNT_W           = 3;

endpackage

`default_nettype wire

// File: rtl/dm_array.sv
// ============================================================================
// Module : dm_array
// Brief  : DEPTH x 32 word store, byte-enabled write, combinational read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dm_array
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH = C_DEPTH_DEFAULT,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o,
    output logic [31:0]   merged_o
);

    logic [31:0] mem_q [DEPTH];

    always_comb begin
        rdata_o = '0;
        if (32'(addr_i) < DEPTH) begin
            rdata_o = mem_q[addr_i];
        end
    end

    // The merged word doubles as the write data and the logged value.
    for (genvar l = 0; l < 4; l++) begin : g_lane
        assign merged_o[8*l +: 8] = be_i[l] ? wdata_i[8*l +: 8] : rdata_o[8*l +: 8];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= merged_o;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dm_responder.sv
// ============================================================================
// Module : dm_responder
// Brief  : Fixed-latency data-memory responder with store commit logging.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH   = C_DEPTH_DEFAULT,
    parameter logic [31:0] BASE    = C_BASE_DEFAULT,
    parameter int unsigned LATENCY = C_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        log_valid,
    output logic [31:0] log_pc,
    output logic [31:0] log_addr,
    output logic [31:0] log_data
);

    localparam int unsigned         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0]         C_SPAN     = 32'(4 * DEPTH);
    localparam logic [C_CNT_W-1:0]  C_CNT_LOAD = C_CNT_W'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > C_LATENCY_MAX) begin : g_latency_check
        $error("dm_responder: LATENCY out of range 1..7");
    end

    dm_state_e          state_q, state_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic               we_q;
    logic [31:0]        addr_q, wdata_q, pc_q;
    logic [3:0]         be_q;

    logic               rsp_err_q, log_valid_q;
    logic [31:0]        rsp_rdata_q, log_pc_q, log_addr_q, log_data_q;

    logic               w_accept, w_enter_resp, w_err, w_mem_we;
    logic               w_cur_we;
    logic [31:0]        w_cur_addr, w_cur_wdata, w_cur_pc, w_off;
    logic [3:0]         w_cur_be;
    logic [31:0]        w_rdata, w_merged;

    // With LATENCY==1 RESP is entered on the acceptance edge itself, before
    // the request latch holds anything, so the live request is used there.
    assign w_cur_we    = (state_q == ST_IDLE) ? req_we    : we_q;
    assign w_cur_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign w_cur_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign w_cur_be    = (state_q == ST_IDLE) ? req_be    : be_q;
    assign w_cur_pc    = (state_q == ST_IDLE) ? req_pc    : pc_q;

    assign w_off    = w_cur_addr - BASE;
    assign w_err    = (w_cur_addr[1:0] != 2'b00) || (w_cur_addr < BASE) || (w_off >= C_SPAN);
    assign w_mem_we = w_enter_resp && w_cur_we && !w_err;

    dm_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .we_i     (w_mem_we),
        .addr_i   (w_off[AW+1:2]),
        .be_i     (w_cur_be),
        .wdata_i  (w_cur_wdata),
        .rdata_o  (w_rdata),
        .merged_o (w_merged)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d      = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = C_CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= C_CNT_W'(1)) begin
                    state_d      = ST_RESP;
                    w_enter_resp = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q - C_CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            pc_q        <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            log_valid_q <= 1'b0;
            log_pc_q    <= '0;
            log_addr_q  <= '0;
            log_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            log_valid_q <= 1'b0;
            if (w_accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
                pc_q    <= req_pc;
            end
            if (w_enter_resp) begin
                rsp_err_q   <= w_err;
                rsp_rdata_q <= (!w_cur_we && !w_err) ? w_rdata : 32'h0;
                if (w_cur_we && !w_err) begin
                    log_valid_q <= 1'b1;
                    log_pc_q    <= w_cur_pc;
                    log_addr_q  <= {w_cur_addr[31:2], 2'b00};
                    log_data_q  <= w_merged;
                end
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE) && reset;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign log_valid = log_valid_q;
    assign log_pc    = log_pc_q;
    assign log_addr  = log_addr_q;
    assign log_data  = log_data_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_responder.sv
// ============================================================================
// Module : tb_dm_responder
// Brief  : Directed self-checking bench for dm_responder (LATENCY 2, 1 and 7).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, v1 = 1'b0, v7 = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_ready = 1'b0;

    logic        req_ready, rsp_valid, rsp_err, log_valid;
    logic [31:0] rsp_rdata, log_pc, log_addr, log_data;
    logic        rr1, rv1, re1, lv1, rr7, rv7, re7, lv7;
    logic [31:0] rd1, lp1, la1, ld1, rd7, lp7, la7, ld7;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dm_responder u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .req_pc(req_pc), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .log_valid(log_valid),
        .log_pc(log_pc), .log_addr(log_addr), .log_data(log_data)
    );

    dm_responder #(.DEPTH(64), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rr1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .req_pc(req_pc), .rsp_valid(rv1), .rsp_ready(1'b1),
        .rsp_rdata(rd1), .rsp_err(re1), .log_valid(lv1),
        .log_pc(lp1), .log_addr(la1), .log_data(ld1)
    );

    dm_responder #(.DEPTH(64), .LATENCY(7)) u_dut_l7 (
        .clk(clk), .reset(reset), .req_valid(v7), .req_ready(rr7),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .req_pc(req_pc), .rsp_valid(rv7), .rsp_ready(1'b1),
        .rsp_rdata(rd7), .rsp_err(re7), .log_valid(lv7),
        .log_pc(lp7), .log_addr(la7), .log_data(ld7)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the LATENCY=2 instance with rsp_ready held high.
    task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic [31:0] pc,
                            output logic [31:0] rdata, output logic err,
                            output logic logv, output logic [31:0] logd,
                            output int lat, output logic tmo);
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_pc = pc;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        tmo   = !rsp_valid;
        rdata = rsp_rdata;
        err   = rsp_err;
        logv  = log_valid;
        logd  = log_data;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || log_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b rsp_err=%b log_valid=%b, required 0 0 0 0",
                     req_ready, rsp_valid, rsp_err, log_valid);
        end
        n_checks++;
        if (rsp_rdata !== 32'h0 || log_pc !== 32'h0 || log_addr !== 32'h0 || log_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h pc=%h addr=%h data=%h, required all 0",
                     rsp_rdata, log_pc, log_addr, log_data);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_store_word();
        logic [31:0] rd, ld; logic er, lv, to; int lat;
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h1234_5678; req_be = 4'hF; req_pc = 32'h3004;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL store_ready_idle: got %b, required 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || log_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL store_cycle1: rsp_valid=%b log_valid=%b req_ready=%b, required 0 0 0",
                     rsp_valid, log_valid, req_ready);
        end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || log_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL store_cycle2: rsp_valid=%b log_valid=%b, required 1 1", rsp_valid, log_valid);
        end
        n_checks++;
        if (log_pc !== 32'h3004 || log_addr !== 32'h10 || log_data !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL store_log: pc=%h addr=%h data=%h, required 00003004 00000010 12345678",
                     log_pc, log_addr, log_data);
        end
        n_checks++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL store_rsp: rdata=%h err=%b, required 00000000 0", rsp_rdata, rsp_err);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if (log_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL store_done: log_valid=%b rsp_valid=%b req_ready=%b, required 0 0 1",
                     log_valid, rsp_valid, req_ready);
        end
        transact(1'b0, 32'h10, 32'h0, 4'h0, 32'h3008, rd, er, lv, ld, lat, to);
        n_checks++;
        if (to || lat != 2 || rd !== 32'h1234_5678 || er !== 1'b0 || lv !== 1'b0) begin
            n_fail++;
            $display("FAIL load_after_store: tmo=%b lat=%0d rdata=%h err=%b log=%b, required 0 2 12345678 0 0",
                     to, lat, rd, er, lv);
        end
    endtask

    task automatic test_partial_store();
        logic [31:0] rd, ld; logic er, lv, to; int lat;
        transact(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 32'h3010, rd, er, lv, ld, lat, to);
        n_checks++;
        if (to || lv !== 1'b1 || ld !== 32'h1234_56AA || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL partial_store_log: tmo=%b log=%b data=%h rdata=%h, required 0 1 123456aa 0",
                     to, lv, ld, rd);
        end
        transact(1'b0, 32'h10, 32'h0, 4'h0, 32'h3014, rd, er, lv, ld, lat, to);
        n_checks++;
        if (to || rd !== 32'h1234_56AA) begin
            n_fail++;
            $display("FAIL partial_load: tmo=%b rdata=%h, required 0 123456aa", to, rd);
        end
        transact(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'h3018, rd, er, lv, ld, lat, to);
        n_checks++;
        if (to || lv !== 1'b1 || ld !== 32'h1234_56AA || er !== 1'b0) begin
            n_fail++;
            $display("FAIL be_zero_store: tmo=%b log=%b data=%h err=%b, required 0 1 123456aa 0",
                     to, lv, ld, er);
        end
        transact(1'b1, 32'h2FFC, 32'hCAFE_F00D, 4'hF, 32'h301C, rd, er, lv, ld, lat, to);
        transact(1'b0, 32'h2FFC, 32'h0, 4'h0, 32'h3020, rd, er, lv, ld, lat, to);
        n_checks++;
        if (to || rd !== 32'hCAFE_F00D || er !== 1'b0) begin
            n_fail++;
            $display("FAIL last_word: tmo=%b rdata=%h err=%b, required 0 cafef00d 0", to, rd, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, ld; logic er, lv, to; int lat;
        transact(1'b0, 32'h12, 32'h0, 4'h0, 32'h4000, rd, er, lv, ld, lat, to);
        n_checks++;
        if (to || er !== 1'b1 || rd !== 32'h0 || lv !== 1'b0) begin
            n_fail++;
            $display("FAIL err_misaligned: tmo=%b err=%b rdata=%h log=%b, required 0 1 0 0", to, er, rd, lv);
        end
        transact(1'b0, 32'h3000, 32'h0, 4'h0, 32'h4004, rd, er, lv, ld, lat, to);
        n_checks++;
        if (to || er !== 1'b1 || rd !== 32'h0 || lv !== 1'b0) begin
            n_fail++;
            $display("FAIL err_range: tmo=%b err=%b rdata=%h log=%b, required 0 1 0 0", to, er, rd, lv);
        end
        transact(1'b1, 32'h11, 32'h0, 4'hF, 32'h4008, rd, er, lv, ld, lat, to);
        n_checks++;
        if (to || er !== 1'b1 || lv !== 1'b0) begin
            n_fail++;
            $display("FAIL err_store: tmo=%b err=%b log=%b, required 0 1 0", to, er, lv);
        end
        transact(1'b0, 32'h10, 32'h0, 4'h0, 32'h400C, rd, er, lv, ld, lat, to);
        n_checks++;
        if (to || rd !== 32'h1234_56AA) begin
            n_fail++;
            $display("FAIL err_no_write: tmo=%b rdata=%h, required 0 123456aa", to, rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, ld; logic er, lv, to; int lat;
        req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0; req_pc = 32'h5000;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_56AA) begin
            n_fail++;
            $display("FAIL bp_first: rsp_valid=%b rdata=%h, required 1 123456aa", rsp_valid, rsp_rdata);
        end
        // A store offered while stalled must be dropped.
        req_we = 1'b1; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_56AA || req_ready !== 1'b0 || log_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: rsp_valid=%b rdata=%h req_ready=%b log=%b, required 1 123456aa 0 0",
                         i, rsp_valid, rsp_rdata, req_ready, log_valid);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: rsp_valid=%b req_ready=%b, required 0 1", rsp_valid, req_ready);
        end
        transact(1'b0, 32'h10, 32'h0, 4'h0, 32'h5004, rd, er, lv, ld, lat, to);
        n_checks++;
        if (to || rd !== 32'h1234_56AA) begin
            n_fail++;
            $display("FAIL bp_ignored_store: tmo=%b rdata=%h, required 0 123456aa", to, rd);
        end
    endtask

    task automatic test_reset_inflight();
        logic [31:0] rd, ld; logic er, lv, to; int lat;
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF; req_be = 4'hF; req_pc = 32'h6000;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        reset = 1'b0;
        tick();
        n_checks++;
        if (log_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL inflight_reset: log=%b rsp_valid=%b req_ready=%b, required 0 0 0",
                     log_valid, rsp_valid, req_ready);
        end
        reset = 1'b1;
        tick();
        transact(1'b0, 32'h20, 32'h0, 4'h0, 32'h6004, rd, er, lv, ld, lat, to);
        n_checks++;
        if (to || rd !== 32'h0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL inflight_no_commit: tmo=%b rdata=%h err=%b, required 0 0 0", to, rd, er);
        end
        transact(1'b0, 32'h10, 32'h0, 4'h0, 32'h6008, rd, er, lv, ld, lat, to);
        n_checks++;
        if (to || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_clears_mem: tmo=%b rdata=%h, required 0", to, rd);
        end
    endtask

    task automatic test_latency();
        req_we = 1'b1; req_addr = 32'h4; req_wdata = 32'h1122_3344; req_be = 4'hF; req_pc = 32'h7000;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        n_checks++;
        if (rv1 !== 1'b1 || lv1 !== 1'b1 || ld1 !== 32'h1122_3344 || la1 !== 32'h4) begin
            n_fail++;
            $display("FAIL lat1: rsp_valid=%b log=%b data=%h addr=%h, required 1 1 11223344 00000004",
                     rv1, lv1, ld1, la1);
        end
        tick();
        req_we = 1'b0; req_addr = 32'h4;
        v7 = 1'b1;
        tick();
        v7 = 1'b0;
        for (int i = 1; i < 7; i++) begin
            n_checks++;
            if (rv7 !== 1'b0) begin
                n_fail++;
                $display("FAIL lat7_early[%0d]: rsp_valid=%b, required 0", i, rv7);
            end
            tick();
        end
        n_checks++;
        if (rv7 !== 1'b1 || re7 !== 1'b0 || rd7 !== 32'h0) begin
            n_fail++;
            $display("FAIL lat7: rsp_valid=%b err=%b rdata=%h, required 1 0 0", rv7, re7, rd7);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_partial_store();
        test_errors();
        test_backpressure();
        test_reset_inflight();
        test_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
